// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, MEM-stage branch redirects,
// and pipeline freeze around variable-latency data-memory accesses.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rn_id,
  input  logic [4:0]       Rm_id,
  input  logic             use_rn_id,
  input  logic             use_rm_id,
  input  logic [4:0]       Rd_ex,
  input  logic             MemtoReg_ex,
  input  logic             RegWrite_ex,
  input  logic             take_branch_mem,
  input  logic             mem_access_mem,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_sel_branch,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirects
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam int WD_W = $clog2(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WD_W-1:0]  r_wd;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_redir;
  logic             w_lu;
  logic             w_wd_exp;
  logic             w_freeze;

  assign w_lu = MemtoReg_ex & RegWrite_ex & (Rd_ex != 5'd31) &
                ((use_rn_id & (Rn_id == Rd_ex)) |
                 (use_rm_id & (Rm_id == Rd_ex)));

  assign w_wd_exp = (r_state == MEM_WAIT) & ~dmem_ready &
                    (r_wd == WD_MAX);

  // An expired watchdog releases the freeze in the same cycle
  assign w_freeze = (r_state == RUN) ?
                    (mem_access_mem & ~dmem_ready) :
                    (~dmem_ready & ~w_wd_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:      if (mem_access_mem & ~dmem_ready) w_next = MEM_WAIT;
      MEM_WAIT: if (dmem_ready | w_wd_exp) w_next = RUN;
      default:  w_next = RUN;
    endcase
  end

  always_comb begin
    dmem_req      = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_sel_branch = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      dmem_req = (r_state == RUN) & mem_access_mem;
      priority case (1'b1)
        w_freeze: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
        end
        take_branch_mem: begin
          pc_sel_branch = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
          ex_mem_flush  = 1'b1;
        end
        w_lu: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
      r_stall   <= '0;
      r_redir   <= '0;
    end else begin
      if (r_state == MEM_WAIT && w_next == MEM_WAIT) begin
        r_wd <= r_wd + WD_W'(1);
      end else begin
        r_wd <= '0;
      end
      if (w_wd_exp) begin
        r_timeout <= 1'b1;
      end
      if (~pc_en && r_stall != '1) begin
        r_stall <= r_stall + CNT_W'(1);
      end
      if (pc_sel_branch && r_redir != '1) begin
        r_redir <= r_redir + CNT_W'(1);
      end
    end
  end

  assign mem_timeout  = r_timeout;
  assign stall_cycles = r_stall;
  assign redirects    = r_redir;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected strobes and counters
// are queued per cycle and checked by an independent monitor.
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    Rn_id, Rm_id, Rd_ex;
  logic          use_rn_id, use_rm_id;
  logic          MemtoReg_ex, RegWrite_ex;
  logic          take_branch_mem, mem_access_mem, dmem_ready;
  logic          dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic          pc_sel_branch, mem_timeout;
  logic [CW-1:0] stall_cycles, redirects;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rn_id(Rn_id), .Rm_id(Rm_id),
    .use_rn_id(use_rn_id), .use_rm_id(use_rm_id),
    .Rd_ex(Rd_ex), .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex),
    .take_branch_mem(take_branch_mem), .mem_access_mem(mem_access_mem),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .pc_sel_branch(pc_sel_branch), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .redirects(redirects)
  );

  always #5 clk = ~clk;

  // {dmem_req, pc_sel, pc/if_id/id_ex/ex_mem/mem_wb en, 4 flushes}
  localparam logic [10:0] NORM = 11'b00_11111_0000;
  localparam logic [10:0] LU   = 11'b00_00111_0100;
  localparam logic [10:0] BR   = 11'b01_11111_1110;
  localparam logic [10:0] MZW  = 11'b10_11111_0000;
  localparam logic [10:0] MFRZ = 11'b10_00001_0001;
  localparam logic [10:0] FRZ  = 11'b00_00001_0001;
  localparam logic [10:0] RST  = 11'b00_00000_1111;

  typedef struct {
    int            id;
    logic [10:0]   s;
    logic          t;
    logic [CW-1:0] st;
    logic [CW-1:0] rd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   vid = 0;

  task automatic step(
    input logic rst, input logic [4:0] rn, input logic [4:0] rm,
    input logic urn, input logic urm, input logic [4:0] rd,
    input logic ld, input logic br, input logic ma, input logic rdy,
    input logic [10:0] es, input logic et,
    input int est, input int erd);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst;
    Rn_id = rn; Rm_id = rm;
    use_rn_id = urn; use_rm_id = urm;
    Rd_ex = rd; MemtoReg_ex = ld; RegWrite_ex = ld;
    take_branch_mem = br; mem_access_mem = ma; dmem_ready = rdy;
    e.id = vid; e.s = es; e.t = et;
    e.st = CW'(est); e.rd = CW'(erd);
    q.push_back(e);
    vid++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [10:0] a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {dmem_req, pc_sel_branch, pc_en, if_id_en, id_ex_en,
           ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           ex_mem_flush, mem_wb_flush};
      total++;
      if (a !== e.s) begin
        bad++;
        $display("FAIL v%0d strobes got=%b want=%b", e.id, a, e.s);
      end
      total++;
      if (stall_cycles !== e.st) begin
        bad++;
        $display("FAIL v%0d stall_cycles got=%0d want=%0d",
                 e.id, stall_cycles, e.st);
      end
      total++;
      if (redirects !== e.rd || mem_timeout !== e.t) begin
        bad++;
        $display("FAIL v%0d redir/timeout got=%0d/%b want=%0d/%b",
                 e.id, redirects, mem_timeout, e.rd, e.t);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    Rn_id = '0; Rm_id = '0; Rd_ex = '0;
    use_rn_id = 0; use_rm_id = 0;
    MemtoReg_ex = 0; RegWrite_ex = 0;
    take_branch_mem = 0; mem_access_mem = 0; dmem_ready = 0;

    // rst rn rm urn urm rd ld br ma rdy  exp  t  st rd
    step(1, 3, 0, 1, 0, 3, 1, 1, 1, 0, RST,  0, 0, 0);
    step(0, 1, 2, 1, 1, 4, 0, 0, 0, 0, NORM, 0, 0, 0);
    step(0, 4, 2, 1, 1, 4, 0, 0, 0, 0, NORM, 0, 0, 0);
    step(0, 3, 7, 1, 1, 3, 1, 0, 0, 0, LU,   0, 0, 0);
    step(0, 8, 9, 1, 1, 2, 0, 0, 0, 0, NORM, 0, 1, 0);
    step(0, 31, 0, 1, 0, 31, 1, 0, 0, 0, NORM, 0, 1, 0);
    step(0, 1, 5, 1, 0, 5, 1, 0, 0, 0, NORM, 0, 1, 0);
    step(0, 1, 5, 1, 1, 5, 1, 0, 0, 0, LU,   0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MZW,  0, 2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MFRZ, 0, 2, 0);
    step(0, 6, 0, 1, 0, 6, 1, 1, 1, 0, FRZ,  0, 3, 0);
    step(0, 6, 0, 1, 0, 6, 1, 1, 1, 0, FRZ,  0, 4, 0);
    step(0, 6, 0, 1, 0, 6, 1, 1, 1, 1, BR,   0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 5, 1);
    step(0, 2, 0, 1, 0, 2, 1, 1, 0, 0, BR,   0, 5, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 5, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MFRZ, 0, 5, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 6, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 7, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 8, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NORM, 0, 9, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 9, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 9, 2);
    for (int i = 0; i < 8; i++) begin
      step(0, 3, 0, 1, 0, 3, 1, 0, 0, 0, LU, 1,
           (9 + i > 15) ? 15 : 9 + i, 2);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 15, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MFRZ, 1, 15, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  1, 15, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST,  0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);

    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain queue left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage CPU. Each cycle it generates the enable and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and applies taken-branch redirects resolved in MEM. It also freezes the pipeline around variable-latency data-memory accesses, with a watchdog and saturating performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 64, MEM_WAIT cycles before watchdog fires (≥2)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Rn_id, Rm_id  in  5  source registers of instruction in ID
- use_rn_id, use_rm_id  in  1  ID instruction actually reads Rn / Rm
- Rd_ex  in  5  destination of instruction in EX
- MemtoReg_ex, RegWrite_ex  in  1  EX instruction is a load writing Rd
- take_branch_mem  in  1  branch in MEM resolved taken (cbz/b/br logic already applied)
- mem_access_mem  in  1  MEM instruction is a load or store
- dmem_ready  in  1  data memory completes access this cycle
- dmem_req  out  1  one-cycle access start pulse
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register write enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load a bubble (all control zero) when enabled
- pc_sel_branch  out  1  PC mux selects branch target from MEM
- mem_timeout  out  1  sticky watchdog flag
- stall_cycles  out  CNT_W  cycles with pc_en=0
- redirects  out  CNT_W  taken-branch redirects

## Operation
- FSM states: RUN, MEM_WAIT. Reset → RUN.
- Outputs are Mealy, computed from state and current inputs. Defaults are all enables 1, all flushes 0, dmem_req 0, pc_sel_branch 0.
- Priority, highest first: freeze, then branch, then load-use.

Freeze:
- RUN with mem_access_mem=1: dmem_req=1.
  - If dmem_ready=1 in the same cycle, this is a zero-wait access: no freeze.
  - Otherwise, enter MEM_WAIT.
- In a RUN cycle with mem_access_mem & !dmem_ready, and in every MEM_WAIT cycle without dmem_ready:
  - pc_en, if_id_en, id_ex_en and ex_mem_en are 0.
  - mem_wb_en=1 with mem_wb_flush=1, so WB sees a bubble.
- MEM_WAIT: dmem_req=0. On dmem_ready=1, release the freeze in that cycle and go to RUN.
- Watchdog counter is cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT-1 without ready:
  - set mem_timeout (sticky until reset);
  - release the freeze that cycle and return to RUN.

Branch (not frozen, take_branch_mem=1):
- pc_sel_branch=1, pc_en=1.
- if_id_flush, id_ex_flush and ex_mem_flush are 1, killing the three younger instructions.
- redirects increments.

Load-use (not frozen, no branch):
- Hazard when MemtoReg_ex & RegWrite_ex & Rd_ex≠31, and either (use_rn_id & Rn_id==Rd_ex) or (use_rm_id & Rm_id==Rd_ex).
- Response: pc_en=0, if_id_en=0, id_ex_flush=1. This lasts one cycle, because the load advances to MEM.
- Register 31 (XZR) never causes a hazard.

Counters:
- stall_cycles increments on every cycle with pc_en=0.
- Both counters saturate at all-ones.

## Timing
- While reset is asserted:
  - state=RUN, watchdog=0, mem_timeout=0, counters=0;
  - all enables 0, all flushes 1, dmem_req=0, pc_sel_branch=0.
- Reset deassertion: normal operation from the next rising edge.
- Reset mid-MEM_WAIT: return to RUN immediately. No dmem_req is reissued until a new RUN cycle with mem_access_mem.
- Latency:
  - Strobe outputs are combinational, with zero-cycle latency from inputs.
  - State, watchdog, counters and mem_timeout update on the rising clk edge.
- Branch during freeze: held off, because the EX/MEM register is frozen. It applies in the cycle ready arrives (both effects in that cycle: branch flushes, mem_wb bubble not inserted).
- Load-use during freeze: suppressed. It is re-evaluated once the freeze releases.
- Load-use and branch in the same cycle: branch only; stall_cycles is not incremented.
- dmem_req is pulsed exactly once per memory instruction, including after a timeout.

## Test plan
- Independent ALU ops, no branches or memory: all enables 1, all flushes 0, counters stay 0.
- LDUR X3 in EX (Rd_ex=3, MemtoReg/RegWrite=1), ID reads Rn=3 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1. Repeat with Rd_ex=31 → no stall.
- Memory instruction with dmem_ready after 3 cycles → dmem_req one pulse; 3 frozen cycles with mem_wb_flush=1; release on the ready cycle; stall_cycles=3.
- MEM_TIMEOUT=4 and dmem_ready never asserts → freeze for 4 cycles, then mem_timeout=1 and stays 1 until reset.
- take_branch_mem=1 while a load-use hazard is present → pc_sel_branch=1, three flushes, pc_en=1; redirects=1; stall_cycles unchanged.
- Assert reset mid-MEM_WAIT, then deassert with dmem_ready=0 and mem_access_mem=0 → RUN, counters 0, no freeze, no dmem_req.
